// File: rtl/delay_bin_generator.sv
// Start/stop photon delay measurement: converts the delay between synchronized
// start and stop edges into a 7-bit histogram bin and strobes it downstream.
module delay_bin_generator #(
    parameter int BIN_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_in,
    input  logic        stop_in,
    input  logic [1:0]  Command,
    output logic [6:0]  addr,
    output logic        Memory_add,
    output logic        busy,
    output logic [15:0] overflow_cnt
);

    localparam int CW = 8 + BIN_SHIFT;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] COUNTING = 2'd2;

    localparam logic [1:0] CMD_CLEAR = 2'b01;
    localparam logic [1:0] CMD_RUN   = 2'b10;

    // 128 << BIN_SHIFT is exactly the MSB of the counter
    localparam logic [CW-1:0] TIMEOUT = {1'b1, {(CW-1){1'b0}}};
    localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]    w_raw;
    logic [1:0]    w_edge;
    logic [1:0]    r_qual;
    logic [1:0]    r_state;
    logic [CW-1:0] r_counter;
    logic [6:0]    r_addr;
    logic          r_mem_add;
    logic [15:0]   r_ovf;
    logic          w_start_edge;
    logic          w_stop_edge;
    logic [6:0]    w_bin;

    assign w_raw = {stop_in, start_in};

    // Marks when the synchronizer output holds a real post-reset sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qual <= 2'b00;
        end else begin
            r_qual <= {r_qual[0], 1'b1};
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic [1:0] r_sync;
            logic       r_prev;
            logic       r_low_seen;
            logic       r_edge;

            // An input must be seen low after reset before its rise counts as an edge
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync     <= 2'b00;
                    r_prev     <= 1'b0;
                    r_low_seen <= 1'b0;
                    r_edge     <= 1'b0;
                end else begin
                    r_sync <= {r_sync[0], w_raw[gi]};
                    r_prev <= r_sync[1];
                    if (r_qual[1] && !r_sync[1]) begin
                        r_low_seen <= 1'b1;
                    end
                    r_edge <= r_low_seen & r_sync[1] & ~r_prev;
                end
            end

            assign w_edge[gi] = r_edge;
        end
    endgenerate

    assign w_start_edge = w_edge[0];
    assign w_stop_edge  = w_edge[1];
    assign w_bin        = r_counter[BIN_SHIFT +: 7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_addr    <= 7'd0;
            r_mem_add <= 1'b0;
            r_ovf     <= 16'd0;
        end else begin
            r_mem_add <= 1'b0;
            if (Command != CMD_RUN) begin
                r_state   <= IDLE;
                r_counter <= '0;
                if (Command == CMD_CLEAR) begin
                    r_ovf <= 16'd0;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= ARMED;
                    end
                    ARMED: begin
                        if (w_start_edge) begin
                            if (w_stop_edge) begin
                                r_addr    <= 7'd0;
                                r_mem_add <= 1'b1;
                            end else begin
                                r_counter <= ONE;
                                r_state   <= COUNTING;
                            end
                        end
                    end
                    COUNTING: begin
                        // Timeout wins over a coincident stop edge
                        if (r_counter == TIMEOUT) begin
                            if (r_ovf != 16'hFFFF) begin
                                r_ovf <= r_ovf + 16'd1;
                            end
                            r_counter <= '0;
                            r_state   <= ARMED;
                        end else if (w_stop_edge) begin
                            r_addr    <= w_bin;
                            r_mem_add <= 1'b1;
                            r_counter <= '0;
                            r_state   <= ARMED;
                        end else begin
                            r_counter <= r_counter + ONE;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_counter <= '0;
                    end
                endcase
            end
        end
    end

    assign addr         = r_addr;
    assign Memory_add   = r_mem_add;
    assign busy         = (r_state == COUNTING);
    assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_delay_bin_generator.sv
// Scoreboard bench for delay_bin_generator: one instance with BIN_SHIFT=0, one with 2.
module tb_delay_bin_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, stop0, start2, stop2;
    logic [1:0]  cmd0, cmd2;
    logic [6:0]  addr0, addr2;
    logic        mem0, mem2, busy0, busy2;
    logic [15:0] ovf0, ovf2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dbl      = 0;
    logic prev_mem0 = 1'b0;
    logic prev_mem2 = 1'b0;

    int obs0_addr[$], obs0_cyc[$], obs2_addr[$], obs2_cyc[$];
    int exp0[$], exp2[$];

    always #5 clk = ~clk;

    delay_bin_generator #(.BIN_SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_in(start0), .stop_in(stop0),
        .Command(cmd0), .addr(addr0), .Memory_add(mem0), .busy(busy0),
        .overflow_cnt(ovf0)
    );

    delay_bin_generator #(.BIN_SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_in(start2), .stop_in(stop2),
        .Command(cmd2), .addr(addr2), .Memory_add(mem2), .busy(busy2),
        .overflow_cnt(ovf2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every strobe with its cycle number
    always @(negedge clk) begin
        if (mem0 === 1'b1) begin
            obs0_addr.push_back(int'(addr0));
            obs0_cyc.push_back(cyc);
            if (prev_mem0) dbl++;
        end
        if (mem2 === 1'b1) begin
            obs2_addr.push_back(int'(addr2));
            obs2_cyc.push_back(cyc);
            if (prev_mem2) dbl++;
        end
        prev_mem0 <= (mem0 === 1'b1);
        prev_mem2 <= (mem2 === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int obs_size(input int sel);
        return (sel == 0) ? obs0_addr.size() : obs2_addr.size();
    endfunction

    task automatic drive(input int sel, input logic st, input logic sp);
        if (sel == 0) begin
            start0 = st;
            stop0  = sp;
        end else begin
            start2 = st;
            stop2  = sp;
        end
    endtask

    // Start pulse, optional retrigger 3 clks later, stop pulse d clks after first start
    task automatic measure(input int sel, input int d, input bit retrig, output int stop_cyc);
        int bs;
        int len;
        bs  = (sel == 0) ? 0 : 2;
        len = (d + 2 > 5) ? d + 2 : 5;
        if (d < (128 << bs)) begin
            if (sel == 0) exp0.push_back(d >> bs);
            else          exp2.push_back(d >> bs);
        end
        stop_cyc = 0;
        for (int k = 0; k < len; k++) begin
            drive(sel, (k < 2) || (retrig && k >= 3 && k < 5), (k >= d) && (k < d + 2));
            if (k == d) stop_cyc = cyc;
            tick(1);
        end
        drive(sel, 1'b0, 1'b0);
    endtask

    task automatic check_strobe(input int sel, input string name, input int stop_cyc);
        int got_addr;
        int got_cyc;
        int want;
        int waited;
        waited = 0;
        while (obs_size(sel) == 0 && waited < 30) begin
            tick(1);
            waited++;
        end
        want = -1;
        if (sel == 0 && exp0.size() > 0) want = exp0.pop_front();
        if (sel != 0 && exp2.size() > 0) want = exp2.pop_front();
        n_checks++;
        if (obs_size(sel) == 0) begin
            n_fail++;
            $display("FAIL %s_strobe: no Memory_add within 30 clks, required addr=%0d", name, want);
        end else begin
            if (sel == 0) begin
                got_addr = obs0_addr.pop_front();
                got_cyc  = obs0_cyc.pop_front();
            end else begin
                got_addr = obs2_addr.pop_front();
                got_cyc  = obs2_cyc.pop_front();
            end
            if (got_addr !== want) begin
                n_fail++;
                $display("FAIL %s_addr: got %0d, required %0d", name, got_addr, want);
            end
            n_checks++;
            if (got_cyc - stop_cyc !== 4) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d clks, required 4", name, got_cyc - stop_cyc);
            end
        end
        tick(4);
        n_checks++;
        if (obs_size(sel) != 0) begin
            n_fail++;
            $display("FAIL %s_extra: got %0d extra strobes, required 0", name, obs_size(sel));
        end
        n_checks++;
        if (((sel == 0) ? busy0 : busy2) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy: got 1 after strobe, required 0", name);
        end
        $display("txn %s: addr required %0d, stop at cyc %0d", name, want, stop_cyc);
    endtask

    task automatic check_none(input int sel, input string name, input int wait_clks);
        tick(wait_clks);
        n_checks++;
        if (obs_size(sel) != 0) begin
            n_fail++;
            $display("FAIL %s_nostrobe: got %0d strobes, required 0", name, obs_size(sel));
            if (sel == 0) begin obs0_addr.delete(); obs0_cyc.delete(); end
            else          begin obs2_addr.delete(); obs2_cyc.delete(); end
        end
        $display("txn %s: no strobe required", name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start0 = 1'b0; stop0 = 1'b0; start2 = 1'b0; stop2 = 1'b0;
        cmd0 = 2'b00; cmd2 = 2'b00;
        tick(3);
        n_checks++;
        if ({addr0, mem0, busy0, ovf0} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_dut0: got addr=%0d mem=%b busy=%b ovf=%0d, required all 0",
                     addr0, mem0, busy0, ovf0);
        end
        n_checks++;
        if ({addr2, mem2, busy2, ovf2} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_dut2: got addr=%0d mem=%b busy=%b ovf=%0d, required all 0",
                     addr2, mem2, busy2, ovf2);
        end
        rst_n = 1'b1;
        cmd0 = 2'b10; cmd2 = 2'b10;
        tick(6);
        $display("txn reset: outputs checked");
    endtask

    task automatic test_basic();
        int sc;
        measure(0, 5, 1'b0, sc);
        check_strobe(0, "d5", sc);
        measure(0, 0, 1'b0, sc);
        check_strobe(0, "same_cycle", sc);
        measure(0, 10, 1'b1, sc);
        check_strobe(0, "retrigger", sc);
    endtask

    task automatic test_overflow();
        int sc;
        drive(0, 1'b1, 1'b0);
        tick(2);
        drive(0, 1'b0, 1'b0);
        tick(6);
        n_checks++;
        if (busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_busy: got %b while counting, required 1", busy0);
        end
        check_none(0, "timeout", 140);
        n_checks++;
        if (ovf0 !== 16'd1) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d, required 1", ovf0);
        end
        measure(0, 127, 1'b0, sc);
        check_strobe(0, "d127", sc);
    endtask

    task automatic test_shift2();
        int sc;
        measure(2, 13, 1'b0, sc);
        check_strobe(2, "s2_d13", sc);
        measure(2, 511, 1'b0, sc);
        check_strobe(2, "s2_d511", sc);
        measure(2, 512, 1'b0, sc);
        check_none(2, "s2_d512", 10);
        n_checks++;
        if (ovf2 !== 16'd1) begin
            n_fail++;
            $display("FAIL s2_ovf: got %0d, required 1", ovf2);
        end
    endtask

    task automatic test_clear_abort();
        int sc;
        cmd0 = 2'b01;
        tick(2);
        n_checks++;
        if (ovf0 !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_ovf: got %0d, required 0", ovf0);
        end
        cmd0 = 2'b10;
        tick(2);
        drive(0, 1'b1, 1'b0);
        tick(2);
        drive(0, 1'b0, 1'b0);
        tick(8);
        cmd0 = 2'b00;
        tick(2);
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %b, required 0", busy0);
        end
        drive(0, 1'b1, 1'b1);
        tick(2);
        drive(0, 1'b0, 1'b0);
        check_none(0, "abort_cmd", 10);
        cmd0 = 2'b10;
        tick(2);
        measure(0, 7, 1'b0, sc);
        check_strobe(0, "after_abort", sc);
    endtask

    task automatic test_reset_abort();
        int sc;
        drive(0, 1'b1, 1'b0);
        tick(2);
        drive(0, 1'b0, 1'b0);
        tick(8);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy0, mem0, addr0, ovf2} !== 25'd0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b mem=%b addr=%0d ovf2=%0d, required all 0",
                     busy0, mem0, addr0, ovf2);
        end
        start0 = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(6);
        drive(0, 1'b1, 1'b1);
        tick(2);
        drive(0, 1'b1, 1'b0);
        check_none(0, "held_start", 10);
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL held_start_busy: got %b, required 0", busy0);
        end
        drive(0, 1'b0, 1'b0);
        tick(4);
        measure(0, 5, 1'b0, sc);
        check_strobe(0, "after_reset", sc);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_shift2();
        test_clear_abort();
        test_reset_abort();
        n_checks++;
        if (dbl != 0 || exp0.size() != 0 || exp2.size() != 0) begin
            n_fail++;
            $display("FAIL final: got %0d back-to-back strobes and %0d unmatched expectations, required 0 and 0",
                     dbl, exp0.size() + exp2.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_bin_generator.md
DELAY_BIN_GENERATOR -- requirements
Module: delay_bin_generator

Interface
REQ-001 SHALL have parameter BIN_SHIFT, default 0; bin width is 2^BIN_SHIFT clock cycles, legal values 0..8.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_in  input  1  raw photon-detector start pulse, asynchronous to clk, minimum 1 clk high.
REQ-005 SHALL have port stop_in  input  1  raw photon-detector stop pulse, asynchronous to clk, minimum 1 clk high.
REQ-006 SHALL have port Command  input  2  mode: 00 idle, 01 clear, 10 run, 11 treated as idle.
REQ-007 SHALL have port addr  output  7  histogram bin index for the downstream histogram memory.
REQ-008 SHALL have port Memory_add  output  1  one-cycle strobe; addr is valid in the same cycle.
REQ-009 SHALL have port busy  output  1  high while in COUNTING.
REQ-010 SHALL have port overflow_cnt  output  16  number of start events with no stop inside the 128-bin window.

Function
REQ-011 SHALL pass start_in and stop_in each through an identical 2-FF synchronizer followed by rising-edge detection, so both channels have equal latency.
REQ-012 SHALL implement states IDLE, ARMED and COUNTING.
REQ-013 SHALL make these state transitions:
- IDLE->ARMED when Command=10.
- Any state->IDLE when Command!=10.
- Leaving COUNTING this way SHALL abort without a strobe.
REQ-014 SHALL, in ARMED on a start edge, load the delay counter with 1 and enter COUNTING.
REQ-015 SHALL, in ARMED with start and stop edges in the same cycle, emit bin 0 and remain in ARMED.
REQ-016 SHALL, in ARMED, ignore stop edges that arrive without a start edge.
REQ-017 SHALL, in COUNTING, increment the counter by 1 each cycle; counter width is 8+BIN_SHIFT bits and it SHALL never wrap.
REQ-018 SHALL, on a stop edge in COUNTING, register addr = counter >> BIN_SHIFT (lower 7 bits) and Memory_add=1 for exactly one cycle, then return to ARMED.
REQ-019 SHALL, when counter = 128<<BIN_SHIFT with no stop edge (timeout), not strobe; SHALL increment overflow_cnt, saturating at 0xFFFF, and return to ARMED.
REQ-020 SHALL treat a stop edge in the same cycle as the timeout as a timeout.
REQ-021 SHALL ignore start edges during COUNTING (no retrigger).
REQ-022 SHALL produce measured delay D = cycles between start-edge and stop-edge detection; output appears 1 cycle after stop-edge detection (4 cycles after raw stop rises).
REQ-023 SHALL, when Command=01, clear overflow_cnt to 0 and hold IDLE for as long as it is asserted.
REQ-024 SHALL keep addr at its last emitted value between strobes.
REQ-025 SHALL never emit Memory_add on two consecutive cycles.

Reset
REQ-026 SHALL, while rst_n=0 (immediately, regardless of clk), force state=IDLE, counter=0, synchronizer and edge registers=0, addr=0, Memory_add=0, busy=0, overflow_cnt=0.
REQ-027 SHALL, when reset asserts mid-measurement, discard the measurement with no strobe; after release, sit in IDLE until Command=10.
REQ-028 SHALL NOT generate an edge from a pulse already high at reset release until it has gone low and risen again.

Verification
REQ-029 SHALL be verified by a bench covering, with BIN_SHIFT=0 and Command=10:
- start rises, stop rises 5 clks later -> one Memory_add pulse with addr=5, 4 clks after stop rise; busy low afterwards.
- start and stop rise on the same clk -> one Memory_add pulse with addr=0.
- start rises, no stop for 130 clks -> no strobe; overflow_cnt=1; next start/stop pair with D=127 -> addr=127.
- start, then a second start 3 clks later, then stop 10 clks after the first start -> single strobe with addr=10.
REQ-030 SHALL be verified by a bench with BIN_SHIFT=2 covering: D=13 -> addr=3; D=511 -> addr=127; D=512 -> overflow, no strobe.
REQ-031 SHALL be verified by a bench covering abort and clear: rst_n low, or Command=00, during COUNTING -> no strobe and state IDLE; Command=01 -> overflow_cnt=0.
